// File: rtl/npu_load_pkg.sv
// Shared definitions for the NPU weight-load path: FSM state encoding and
// default parameter values used by the weight load scheduler.
package npu_load_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } load_state_e;

    localparam int unsigned DEF_ADDR_WIDTH = 13;
    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_MAX_SLOTS  = 4;
    localparam int unsigned DEF_IDX_WIDTH  = 3;

endpackage

// File: rtl/weight_load_sched.sv
// Weight load scheduler: accepts a job descriptor (up to MAX_SLOTS weight
// tensors, each with a target SRAM and expected length), then steers an
// AXI-Stream of weight bytes into the selected SRAMs, one tensor per tlast.
// Stalls while the target SRAM is busy, suppresses writes past the expected
// length and flags tensor-length mismatches.
module weight_load_sched
    import npu_load_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned MAX_SLOTS  = DEF_MAX_SLOTS,
    parameter int unsigned IDX_WIDTH  = DEF_IDX_WIDTH
) (
    input  logic                            s_axis_aclk,
    input  logic                            s_axis_aresetn,
    input  logic [DATA_WIDTH-1:0]           s_axis_tdata,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic                            s_axis_tlast,
    input  logic                            metadata_valid_i,
    output logic                            metadata_ready_o,
    input  logic [2:0]                      weight_num_i,
    input  logic [MAX_SLOTS*IDX_WIDTH-1:0]  sram_idx_i,
    input  logic [MAX_SLOTS*ADDR_WIDTH-1:0] slot_len_i,
    input  logic [2**IDX_WIDTH-1:0]         sram_busy_i,
    output logic                            write_enable,
    output logic [ADDR_WIDTH-1:0]           write_address,
    output logic [DATA_WIDTH-1:0]           write_data,
    output logic [IDX_WIDTH-1:0]            data_type,
    output logic                            busy_o,
    output logic [1:0]                      slot_o,
    output logic                            load_done_o,
    output logic                            err_len_o,
    output logic                            err_cfg_o
);

    localparam int unsigned SLOT_W  = (MAX_SLOTS > 1) ? $clog2(MAX_SLOTS) : 1;
    localparam logic [2:0]  MAX_NUM = 3'(MAX_SLOTS);

    load_state_e           state_q, state_d;
    logic [2:0]            weight_num_q;
    logic [IDX_WIDTH-1:0]  sram_idx_q [MAX_SLOTS];
    logic [ADDR_WIDTH-1:0] slot_len_q [MAX_SLOTS];
    logic [SLOT_W-1:0]     slot_q;
    logic [ADDR_WIDTH-1:0] beat_cnt_q;

    logic [IDX_WIDTH-1:0]  cur_idx;
    logic [ADDR_WIDTH-1:0] cur_len;
    logic [ADDR_WIDTH:0]   cnt_inc;
    logic                  cfg_ok;
    logic                  cfg_take;
    logic                  beat;
    logic                  in_range;
    logic                  len_mismatch;
    logic                  last_slot;

    assign cur_idx      = sram_idx_q[slot_q];
    assign cur_len      = slot_len_q[slot_q];
    assign beat         = s_axis_tvalid && s_axis_tready;
    assign in_range     = beat_cnt_q < cur_len;
    // one bit wider so a saturated counter never aliases onto a valid length
    assign cnt_inc      = {1'b0, beat_cnt_q} + {{ADDR_WIDTH{1'b0}}, 1'b1};
    assign len_mismatch = cnt_inc != {1'b0, cur_len};
    assign last_slot    = 3'(slot_q) == (weight_num_q - 3'd1);
    assign cfg_take     = (state_q == ST_IDLE) && metadata_valid_i;
    assign slot_o       = 2'(slot_q);

    // Descriptor check: too many tensors or a zero-length used slot
    always_comb begin
        cfg_ok = (weight_num_i <= MAX_NUM);
        for (int unsigned k = 0; k < MAX_SLOTS; k++) begin
            if ((3'(k) < weight_num_i) &&
                (slot_len_i[k*ADDR_WIDTH +: ADDR_WIDTH] == '0)) begin
                cfg_ok = 1'b0;
            end
        end
    end

    // FSM state register
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cfg_take && cfg_ok && (weight_num_i != 3'd0)) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (beat && s_axis_tlast && last_slot) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM combinational outputs; tready follows the target SRAM busy flag
    always_comb begin
        metadata_ready_o = 1'b0;
        s_axis_tready    = 1'b0;
        busy_o           = 1'b0;
        case (state_q)
            ST_IDLE: metadata_ready_o = 1'b1;
            ST_LOAD: begin
                s_axis_tready = !sram_busy_i[cur_idx];
                busy_o        = 1'b1;
            end
            ST_DONE: busy_o = 1'b1;
            default: ;
        endcase
    end

    // Job config latch, slot/beat tracking and registered write/status outputs
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            weight_num_q  <= '0;
            slot_q        <= '0;
            beat_cnt_q    <= '0;
            write_enable  <= 1'b0;
            write_address <= '0;
            write_data    <= '0;
            data_type     <= '0;
            load_done_o   <= 1'b0;
            err_len_o     <= 1'b0;
            err_cfg_o     <= 1'b0;
            for (int unsigned k = 0; k < MAX_SLOTS; k++) begin
                sram_idx_q[k] <= '0;
                slot_len_q[k] <= '0;
            end
        end else begin
            write_enable <= 1'b0;
            load_done_o  <= 1'b0;
            err_len_o    <= 1'b0;
            err_cfg_o    <= 1'b0;

            if (cfg_take) begin
                if (!cfg_ok) begin
                    err_cfg_o <= 1'b1;
                end else if (weight_num_i == 3'd0) begin
                    load_done_o <= 1'b1;
                end else begin
                    weight_num_q <= weight_num_i;
                    slot_q       <= '0;
                    beat_cnt_q   <= '0;
                    for (int unsigned k = 0; k < MAX_SLOTS; k++) begin
                        sram_idx_q[k] <= sram_idx_i[k*IDX_WIDTH +: IDX_WIDTH];
                        slot_len_q[k] <= slot_len_i[k*ADDR_WIDTH +: ADDR_WIDTH];
                    end
                end
            end

            if (beat) begin
                // overrun beats are consumed but leave the write bus untouched
                if (in_range) begin
                    write_enable  <= 1'b1;
                    write_address <= beat_cnt_q;
                    write_data    <= s_axis_tdata;
                    data_type     <= cur_idx;
                end
                if (s_axis_tlast) begin
                    err_len_o  <= len_mismatch;
                    beat_cnt_q <= '0;
                    if (last_slot) begin
                        load_done_o <= 1'b1;
                    end else begin
                        slot_q <= slot_q + SLOT_W'(1);
                    end
                end else if (!cnt_inc[ADDR_WIDTH]) begin
                    beat_cnt_q <= cnt_inc[ADDR_WIDTH-1:0];
                end
            end

            if (state_q == ST_DONE) begin
                slot_q <= '0;
            end
        end
    end

endmodule
